// File: rtl/fwd_sel_reg_pkg.sv
// Shared pipeline definitions for the operand-forwarding stage.
// State encoding and default datapath width.
package fwd_sel_reg_pkg;

  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    VALID = 2'd1,
    HELD  = 2'd2
  } fwd_state_e;

endpackage

// File: rtl/fwd_sel_reg_mux.sv
// N-input combinational selector; out-of-range select yields zero.
// Also flags the out-of-range condition for the capture stage.
module mux_n #(
  parameter int DATA_W = 32,
  parameter int N_IN   = 3,
  parameter int SEL_W  = 2
) (
  input  logic [SEL_W-1:0]       sel_i,
  input  logic [N_IN*DATA_W-1:0] data_i,
  output logic [DATA_W-1:0]      y_o,
  output logic                   err_o
);

  localparam int unsigned NU = N_IN;

  always_comb begin
    y_o = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (sel_i == SEL_W'(i)) begin
        y_o = data_i[i*DATA_W +: DATA_W];
      end
    end
  end

  assign err_o = (32'(sel_i) >= NU);

endmodule

// File: rtl/fwd_sel_reg.sv
// Forwarding operand select with registered output, stall hold,
// flush squash and saturating stall-duration counter.
module fwd_sel_reg
  import fwd_sel_reg_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int N_IN        = 3,
  parameter int SEL_W       = 2,
  parameter int STALL_CNT_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [SEL_W-1:0]       flag,
  input  logic [N_IN*DATA_W-1:0] data_in,
  input  logic                   in_valid,
  input  logic                   stall,
  input  logic                   flush,
  output logic [DATA_W-1:0]      out,
  output logic                   out_valid,
  output logic                   sel_err,
  output logic                   held,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  fwd_state_e             state_q, state_d;
  logic [DATA_W-1:0]      out_q, out_d;
  logic                   vld_q, vld_d;
  logic                   err_q, err_d;
  logic                   held_q, held_d;
  logic [STALL_CNT_W-1:0] cnt_q, cnt_d;

  logic [DATA_W-1:0] mux_y;
  logic              mux_err;

  mux_n #(
    .DATA_W (DATA_W),
    .N_IN   (N_IN),
    .SEL_W  (SEL_W)
  ) u_mux (
    .sel_i  (flag),
    .data_i (data_in),
    .y_o    (mux_y),
    .err_o  (mux_err)
  );

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    vld_d   = vld_q;
    err_d   = err_q;
    held_d  = held_q;
    cnt_d   = cnt_q;
    priority case (1'b1)
      flush: begin
        state_d = EMPTY;
        out_d   = '0;
        vld_d   = 1'b0;
        err_d   = 1'b0;
        held_d  = 1'b0;
        cnt_d   = '0;
      end
      stall: begin
        if (state_q != EMPTY) begin
          state_d = HELD;
          held_d  = 1'b1;
          cnt_d   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        end else begin
          held_d  = 1'b0;
          cnt_d   = '0;
        end
      end
      in_valid: begin
        state_d = VALID;
        out_d   = mux_y;
        vld_d   = 1'b1;
        err_d   = mux_err;
        held_d  = 1'b0;
        cnt_d   = '0;
      end
      default: begin
        state_d = EMPTY;
        out_d   = '0;
        vld_d   = 1'b0;
        err_d   = 1'b0;
        held_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      out_q   <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      held_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      held_q  <= held_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out       = out_q;
  assign out_valid = vld_q;
  assign sel_err   = err_q;
  assign held      = held_q;
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_fwd_sel_reg.sv
// Bench for fwd_sel_reg: two builds (3-input and 5-input) checked
// every cycle against a behavioural model, plus directed pins.
module tb_fwd_sel_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         stall = 1'b0;
  logic         flush = 1'b0;
  logic [1:0]   flag3 = '0;
  logic [95:0]  data3 = '0;
  logic [2:0]   flag5 = '0;
  logic [159:0] data5 = '0;

  logic [31:0] d_out [2];
  logic        d_vld [2];
  logic        d_err [2];
  logic        d_held[2];
  logic [3:0]  d_cnt [2];

  fwd_sel_reg #(.DATA_W(32), .N_IN(3), .SEL_W(2), .STALL_CNT_W(4)) dut3 (
    .clk(clk), .rst(rst), .flag(flag3), .data_in(data3),
    .in_valid(in_valid), .stall(stall), .flush(flush),
    .out(d_out[0]), .out_valid(d_vld[0]), .sel_err(d_err[0]),
    .held(d_held[0]), .stall_cnt(d_cnt[0])
  );

  fwd_sel_reg #(.DATA_W(32), .N_IN(5), .SEL_W(3), .STALL_CNT_W(4)) dut5 (
    .clk(clk), .rst(rst), .flag(flag5), .data_in(data5),
    .in_valid(in_valid), .stall(stall), .flush(flush),
    .out(d_out[1]), .out_valid(d_vld[1]), .sel_err(d_err[1]),
    .held(d_held[1]), .stall_cnt(d_cnt[1])
  );

  // Behavioural model: a "live" operand is simply m_vld.
  logic [31:0] m_out [2];
  logic        m_vld [2];
  logic        m_err [2];
  logic        m_held[2];
  int          m_cnt [2];

  int checks = 0;
  int passed = 0;
  bit chk_en = 1'b0;

  task automatic clear_m(input int k);
    m_out[k] = '0; m_vld[k] = 1'b0; m_err[k] = 1'b0;
    m_held[k] = 1'b0; m_cnt[k] = 0;
  endtask

  task automatic upd(input int k, input int n, input int f,
                     input logic [31:0] c);
    if (rst || flush) begin
      clear_m(k);
    end else if (stall) begin
      if (m_vld[k]) begin
        m_held[k] = 1'b1;
        m_cnt[k]  = (m_cnt[k] + 1 > 15) ? 15 : m_cnt[k] + 1;
      end else begin
        m_held[k] = 1'b0;
        m_cnt[k]  = 0;
      end
    end else if (in_valid) begin
      m_vld[k]  = 1'b1;
      m_err[k]  = (f >= n);
      m_out[k]  = (f >= n) ? 32'h0 : c;
      m_held[k] = 1'b0;
      m_cnt[k]  = 0;
    end else begin
      clear_m(k);
    end
  endtask

  always @(posedge clk) begin
    int f3, f5;
    logic [31:0] c3, c5;
    f3 = int'(flag3);
    f5 = int'(flag5);
    c3 = (f3 < 3) ? data3[f3*32 +: 32] : 32'h0;
    c5 = (f5 < 5) ? data5[f5*32 +: 32] : 32'h0;
    upd(0, 3, f3, c3);
    upd(1, 5, f5, c5);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (d_out[k] === m_out[k] && d_vld[k] === m_vld[k] &&
            d_err[k] === m_err[k] && d_held[k] === m_held[k] &&
            d_cnt[k] === 4'(m_cnt[k])) begin
          passed++;
        end else begin
          $display("FAIL model[%0d] t=%0t got out=%h v=%b e=%b h=%b c=%0d exp out=%h v=%b e=%b h=%b c=%0d",
                   k, $time, d_out[k], d_vld[k], d_err[k], d_held[k], d_cnt[k],
                   m_out[k], m_vld[k], m_err[k], m_held[k], m_cnt[k]);
        end
      end
    end
  end

  task automatic pin(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s got %h exp %h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [95:0] rnd96();
    return {$urandom, $urandom, $urandom};
  endfunction

  function automatic logic [159:0] rnd160();
    return {$urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    // reset held two cycles with random inputs
    rst = 1'b1; in_valid = 1'b1; stall = 1'b0;
    flag3 = 2'($urandom); data3 = rnd96();
    flag5 = 3'($urandom); data5 = rnd160();
    tick();
    chk_en = 1'b1;
    data3 = rnd96(); data5 = rnd160();
    tick();
    for (int k = 0; k < 2; k++) begin
      pin("rst_out",  d_out[k], 32'h0);
      pin("rst_vld",  32'(d_vld[k]), 32'h0);
      pin("rst_err",  32'(d_err[k]), 32'h0);
      pin("rst_held", 32'(d_held[k]), 32'h0);
      pin("rst_cnt",  32'(d_cnt[k]), 32'h0);
    end

    // select sweep on the 3-input build
    rst = 1'b0; in_valid = 1'b1;
    data3 = {32'h33333333, 32'h22222222, 32'h11111111};
    for (int f = 0; f < 4; f++) begin
      flag3 = 2'(f);
      tick();
      pin("sweep_out", d_out[0],
          (f == 0) ? 32'h11111111 : (f == 1) ? 32'h22222222 :
          (f == 2) ? 32'h33333333 : 32'h0);
      pin("sweep_err", 32'(d_err[0]), (f == 3) ? 32'h1 : 32'h0);
    end

    // capture then 20-cycle stall with churning inputs
    flag3 = 2'd1;
    tick();
    pin("cap_out", d_out[0], 32'h22222222);
    stall = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      data3 = rnd96(); flag3 = 2'($urandom);
      in_valid = 1'($urandom);
      tick();
      pin("stall_out",  d_out[0], 32'h22222222);
      pin("stall_held", 32'(d_held[0]), 32'h1);
      pin("stall_cnt",  32'(d_cnt[0]), (i < 15) ? 32'(i) : 32'd15);
    end

    // release with new operand the same cycle
    stall = 1'b0; in_valid = 1'b1; flag3 = 2'd2;
    data3 = {32'h33333333, 32'h22222222, 32'h11111111};
    tick();
    pin("rel_out",  d_out[0], 32'h33333333);
    pin("rel_held", 32'(d_held[0]), 32'h0);
    pin("rel_cnt",  32'(d_cnt[0]), 32'h0);

    // flush beats stall and in_valid
    flush = 1'b1; stall = 1'b1;
    tick();
    pin("fl_out", d_out[0], 32'h0);
    pin("fl_vld", 32'(d_vld[0]), 32'h0);
    flush = 1'b0;
    tick();
    pin("fl_stall_held", 32'(d_held[0]), 32'h0);
    pin("fl_stall_vld",  32'(d_vld[0]), 32'h0);

    // mid-stall reset on the 5-input build
    stall = 1'b0; in_valid = 1'b1; flag5 = 3'd1;
    data5 = {32'h55555555, 32'h44444444, 32'h33333333,
             32'h22222222, 32'h11111111};
    tick();
    stall = 1'b1;
    tick();
    tick();
    pin("ms_held2", 32'(d_cnt[1]), 32'h2);
    rst = 1'b1;
    tick();
    pin("ms_out",  d_out[1], 32'h0);
    pin("ms_vld",  32'(d_vld[1]), 32'h0);
    pin("ms_held", 32'(d_held[1]), 32'h0);
    pin("ms_cnt",  32'(d_cnt[1]), 32'h0);
    rst = 1'b0; stall = 1'b0; flag5 = 3'd4;
    tick();
    pin("n5_f4", d_out[1], 32'h55555555);
    flag5 = 3'd6;
    tick();
    pin("n5_f6_out", d_out[1], 32'h0);
    pin("n5_f6_err", 32'(d_err[1]), 32'h1);

    // randomized traffic checked by the model each cycle
    for (int i = 0; i < 600; i++) begin
      rst      = ($urandom_range(0, 39) == 0);
      flush    = ($urandom_range(0, 11) == 0);
      stall    = ($urandom_range(0, 2) == 0) ||
                 (i % 100 >= 60 && i % 100 < 85);
      in_valid = ($urandom_range(0, 3) != 0);
      flag3 = 2'($urandom); data3 = rnd96();
      flag5 = 3'($urandom); data5 = rnd160();
      tick();
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/fwd_sel_reg.md
# fwd_sel_reg

- Parametrised N-input operand-forwarding selector with a registered output stage.
- Sits between the forwarding-select logic and the EX-stage operand register of the pipeline.
- Chooses one of N_IN candidate values (register file, EX/MEM result, MEM/WB result, …) by `flag` and captures it.
- Honours pipeline stall and flush, and reports out-of-range selects and stall duration.

## Interface

Parameters:
- DATA_W, 32, width of each candidate value and of `out`
- N_IN, 3, number of candidate inputs (2..16)
- SEL_W, 2, width of `flag`; must satisfy 2^SEL_W >= N_IN
- STALL_CNT_W, 4, width of the saturating stall counter

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- flag  in  SEL_W  candidate select; index i selects `data_in[i*DATA_W +: DATA_W]`
- data_in  in  N_IN*DATA_W  flattened candidates; candidate 0 in the LSBs
- in_valid  in  1  current instruction carries a real operand
- stall  in  1  hold the stage
- flush  in  1  squash the stage contents
- out  out  DATA_W  registered selected operand
- out_valid  out  1  `out` holds a live operand
- sel_err  out  1  captured operand came from an out-of-range `flag`
- held  out  1  stage is currently being held by a stall
- stall_cnt  out  STALL_CNT_W  consecutive held cycles, saturating

## Operation

- FSM states:
  - EMPTY: no live operand.
  - VALID: live operand captured this cycle.
  - HELD: live operand being held under a stall.
- Per-cycle priority: `rst` > `flush` > `stall` > capture.
- rst: state EMPTY; `out`=0, `out_valid`=0, `sel_err`=0, `held`=0, `stall_cnt`=0. Applies mid-stall or mid-anything.
- flush (no rst): same register values as reset; state EMPTY. `stall` and `in_valid` are ignored that cycle.
- stall, state VALID or HELD:
  - state becomes HELD; `out`, `out_valid`, `sel_err` unchanged; `held`=1.
  - `stall_cnt` increments, saturating at 2^STALL_CNT_W−1.
- stall, state EMPTY: stay EMPTY; all outputs unchanged; `held`=0; `stall_cnt` stays 0. No capture.
- No stall, `in_valid`=1:
  - `out` = selected candidate; `out_valid`=1.
  - `sel_err` = (`flag` >= N_IN); when set, `out`=0.
  - `held`=0, `stall_cnt`=0; state VALID.
- No stall, `in_valid`=0: `out`=0, `out_valid`=0, `sel_err`=0, `held`=0, `stall_cnt`=0; state EMPTY. `flag` is ignored.
- Select decode is purely combinational before the register; no arithmetic on data.
- `stall_cnt` is unsigned and never wraps.

## Timing

- Latency is 1 cycle: inputs sampled at edge k appear on `out` after edge k.
- No combinational path from any input to any output.
- `held` rises on the first stalled edge and falls on the first non-stalled edge (or flush/rst).
- Releasing a stall and presenting a new operand in the same cycle: the new operand is captured at that edge.
- `stall` and `flush` asserted together: flush wins; the stage is EMPTY afterwards.
- `flag` and `data_in` may change freely while stalled; the held value is unaffected.

## Structure

- Shared pipeline package holds:
  - the FSM state encoding localparams: EMPTY=2'd0, VALID=2'd1, HELD=2'd2
  - the default DATA_W=32
- One natural sub-module: `mux_n`, a purely combinational N-input parametrised selector with zero on out-of-range select. It is instantiated once, ahead of the register and FSM.

## Test plan

- Reset: hold rst 2 cycles with random inputs -> `out`=0, `out_valid`=0, `sel_err`=0, `held`=0, `stall_cnt`=0.
- Select sweep, N_IN=3, candidates 0x11111111 / 0x22222222 / 0x33333333, `in_valid`=1:
  - `flag`=0,1,2 -> `out` equals the matching candidate one cycle later, `sel_err`=0.
  - `flag`=3 -> `out`=0, `sel_err`=1.
- Stall hold: capture 0x22222222, then stall 20 cycles while `data_in` changes:
  - `out` stays 0x22222222 and `held`=1 throughout.
  - `stall_cnt` counts 1..15 then saturates at 15.
- Stall release with new operand: same cycle as `stall` drops, present `flag`=2 -> next cycle `out`=0x33333333, `held`=0, `stall_cnt`=0.
- Flush priority: assert `flush` together with `stall` and `in_valid` -> `out`=0, `out_valid`=0, state EMPTY; stall on EMPTY afterwards keeps `held`=0.
- Mid-stall reset, N_IN=5 / SEL_W=3 build: reset asserted on the 3rd held cycle -> all outputs 0. Next capture with `flag`=4 gives candidate 4; `flag`=6 gives `out`=0 with `sel_err`=1.
